prog_mem_loadable: RTL and testbench

//  Parametrised, run-time loadable program memory for the picoMIPS core; replaces the fixed case-table ROM.
//  - Holds 2**Psize instruction words of Isize bits.
//  - Serves registered instruction fetch to the CPU.
//  - Accepts a new program over a valid/ready load stream while holding the CPU stalled.
//  - Unloaded addresses return DEFAULT_I ("B 0", PC=0).

---
 rtl/prog_mem_loadable.sv | 128 ++++++++++++
 tb/tb_prog_mem_loadable.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loadable.sv
// Run-time loadable picoMIPS program memory with registered fetch and a valid/ready load port.
// Define PROG_CHECKSUM_EN to treat the ld_last word as an XOR checksum instead of program data.
module prog_mem_loadable #(
    parameter int unsigned      Psize     = 5,
    parameter int unsigned      Isize     = 14,
    parameter logic [Isize-1:0] DEFAULT_I = {2'b11, {(Isize - 2){1'b0}}}
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [Psize-1:0] address,
    output logic [Isize-1:0] I,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [Isize-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             cpu_hold,
    output logic             ld_done,
    output logic [Psize:0]   ld_words,
    output logic             ld_err
);

    localparam int unsigned    DEPTH   = 1 << Psize;
    localparam logic [Psize:0] DEPTH_W = (Psize + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e           state_q, state_d;
    logic [Isize-1:0] mem [DEPTH];
    logic [Psize:0]   words_q;
    logic             err_q, ready_q, hold_q;
    logic [Isize-1:0] i_q;
    logic             accept, full, store, bad, finish;

    assign accept = (state_q == StLoad) && ld_valid && ready_q;
    assign full   = (words_q == DEPTH_W);
    assign finish = accept && ld_last;

`ifdef PROG_CHECKSUM_EN
    logic [Isize-1:0] sum_q;

    assign store = accept && !ld_last && !full;
    assign bad   = (accept && !ld_last && full) || (finish && (sum_q != ld_data));

    // Running XOR of stored words only; the checksum word itself is never folded in.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sum_q <= '0;
        end else if (state_q == StIdle && ld_start) begin
            sum_q <= '0;
        end else if (store) begin
            sum_q <= sum_q ^ ld_data;
        end
    end
`else
    assign store = accept && !full;
    assign bad   = accept && full;
`endif

    // State register
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ld_start) state_d = StLoad;
            StLoad:  if (finish)   state_d = StDone;
            StDone:                state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        ld_done = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            words_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            i_q     <= DEFAULT_I;
        end else begin
            if (state_q == StIdle && ld_start) begin
                words_q <= '0;
                err_q   <= 1'b0;
                ready_q <= 1'b1;
                hold_q  <= 1'b1;
            end else begin
                if (store) words_q <= words_q + 1'b1;
                if (bad)   err_q   <= 1'b1;
                // Hold drops on the accepting edge so it is already low during the done pulse.
                if (finish) begin
                    ready_q <= 1'b0;
                    hold_q  <= 1'b0;
                end
            end
            if (hold_q || ({1'b0, address} >= words_q)) begin
                i_q <= DEFAULT_I;
            end else begin
                i_q <= mem[address];
            end
        end
    end

    // Array contents are deliberately not reset; ld_words gates every read.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[words_q[Psize-1:0]] <= ld_data;
        end
    end

    assign I        = i_q;
    assign ld_ready = ready_q;
    assign cpu_hold = hold_q;
    assign ld_words = words_q;
    assign ld_err   = err_q;

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Self-checking bench for prog_mem_loadable: program-level reference model plus literal spot checks.
// Follows PROG_CHECKSUM_EN the same way as the design.
module tb_prog_mem_loadable;

    localparam int         DEPTH = 32;
    localparam logic [13:0] DEF  = 14'h3000;

    logic        clk, nReset;
    logic [4:0]  address;
    logic [13:0] I;
    logic        ld_start, ld_valid, ld_last;
    logic [13:0] ld_data;
    logic        ld_ready, cpu_hold, ld_done, ld_err;
    logic [5:0]  ld_words;

    prog_mem_loadable #(.Psize(5), .Isize(14)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .address  (address),
        .I        (I),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_hold (cpu_hold),
        .ld_done  (ld_done),
        .ld_words (ld_words),
        .ld_err   (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 loading (CPU held), 2 one-cycle done pulse.
    int          m_phase;
    logic [13:0] m_prog [DEPTH];
    int          m_cnt;
    bit          m_err;
    logic [13:0] m_xor, m_I;
    bit          model_on = 1'b0;
    bit          rnd_addr = 1'b0;
    int          done_seen = 0;

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_xor   = '0;
        m_I     = DEF;
    endtask

    always @(negedge nReset) model_reset();

    always @(posedge clk) begin
        if (nReset) begin
            if (m_phase == 1 || int'(address) >= m_cnt) m_I = DEF;
            else m_I = m_prog[address];
            case (m_phase)
                0: if (ld_start) begin
                    m_phase = 1; m_cnt = 0; m_err = 1'b0; m_xor = '0;
                end
                1: if (ld_valid) begin
`ifdef PROG_CHECKSUM_EN
                    if (ld_last) begin
                        if (m_xor != ld_data) m_err = 1'b1;
                    end else if (m_cnt < DEPTH) begin
                        m_prog[m_cnt] = ld_data; m_cnt++; m_xor ^= ld_data;
                    end else m_err = 1'b1;
`else
                    if (m_cnt < DEPTH) begin
                        m_prog[m_cnt] = ld_data; m_cnt++;
                    end else m_err = 1'b1;
`endif
                    if (ld_last) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Single compare process: every cycle outside reset.
    always @(negedge clk) begin
        if (nReset && model_on) begin
            chk("I",        32'(I),        32'(m_I));
            chk("ld_ready", 32'(ld_ready), 32'(m_phase == 1));
            chk("cpu_hold", 32'(cpu_hold), 32'(m_phase == 1));
            chk("ld_done",  32'(ld_done),  32'(m_phase == 2));
            chk("ld_words", 32'(ld_words), 32'(m_cnt));
            chk("ld_err",   32'(ld_err),   32'(m_err));
            if (ld_done) done_seen++;
        end
    end

    task automatic tick();
        if (rnd_addr) address = 5'($urandom_range(0, 31));
        @(negedge clk);
    endtask

    task automatic start();
        ld_start = 1'b1; tick(); ld_start = 1'b0;
    endtask

    task automatic send(input logic [13:0] d, input bit last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fetch_chk(input string name, input logic [4:0] a, input logic [13:0] exp);
        address = a; @(negedge clk);
        chk(name, 32'(I), 32'(exp));
    endtask

    initial begin
        int d0, len;
        logic [13:0] x, w;
        nReset = 1'b0; address = 5'd3;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_I", 32'(I), 32'h3000);
        chk("rst_words", 32'(ld_words), 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_ready", 32'(ld_ready), 0);
        chk("rst_done", 32'(ld_done), 0);
        chk("rst_err", 32'(ld_err), 0);
        #2 nReset = 1'b1;
        model_on = 1'b1;
        @(negedge clk);
        chk("fetch_after_rst", 32'(I), 32'h3000);

`ifdef PROG_CHECKSUM_EN
        start(); send(14'h0001, 0); send(14'h0002, 0); send(14'h0003, 1);
        tick();
        chk("sum_ok_words", 32'(ld_words), 2);
        chk("sum_ok_err", 32'(ld_err), 0);
        start(); send(14'h0001, 0); send(14'h0002, 0); send(14'h0007, 1);
        tick();
        chk("sum_bad_err", 32'(ld_err), 1);
        chk("sum_bad_words", 32'(ld_words), 2);
        fetch_chk("sum_bad_kept", 5'd1, 14'h0002);
`else
        d0 = done_seen;
        start();
        chk("load_hold", 32'(cpu_hold), 1);
        send(14'h2080, 0); send(14'h2480, 0); send(14'h3084, 0); send(14'h2040, 1);
        chk("done_pulse", 32'(ld_done), 1);
        chk("done_hold", 32'(cpu_hold), 0);
        tick();
        chk("done_once", 32'(done_seen - d0), 1);
        chk("four_words", 32'(ld_words), 4);
        fetch_chk("fetch_a2", 5'd2, 14'h3084);
        fetch_chk("fetch_a4", 5'd4, 14'h3000);
`endif

        // Overflow: the first 32 words survive, the rest are discarded with ld_err set.
        start();
`ifdef PROG_CHECKSUM_EN
        for (int i = 0; i < 33; i++) send(14'(14'h0100 + i), 0);
        send(14'h0000, 1);
`else
        for (int i = 0; i < 33; i++) send(14'(14'h0100 + i), i == 32);
`endif
        tick();
        chk("ovf_words", 32'(ld_words), 32);
        chk("ovf_err", 32'(ld_err), 1);
        for (int a = 0; a < 32; a++) fetch_chk("ovf_mem", 5'(a), 14'(14'h0100 + a));

        // Spurious start mid-load, stray last without valid, valid while idle.
        start(); send(14'h00aa, 0);
        ld_start = 1'b1; ld_last = 1'b1; tick(); ld_start = 1'b0; ld_last = 1'b0;
        send(14'h00bb, 1);
        tick();
`ifdef PROG_CHECKSUM_EN
        chk("spur_words", 32'(ld_words), 1);
`else
        chk("spur_words", 32'(ld_words), 2);
`endif
        ld_valid = 1'b1; ld_data = 14'h3fff; repeat (3) tick(); ld_valid = 1'b0;
        chk("idle_valid_words", 32'(ld_words), 32'(m_cnt));
        fetch_chk("spur_mem0", 5'd0, 14'h00aa);

        // Reset in the middle of a load.
        start(); send(14'h1111, 0); send(14'h2222, 0);
        #2 nReset = 1'b0;
        #1;
        chk("midrst_words", 32'(ld_words), 0);
        chk("midrst_hold", 32'(cpu_hold), 0);
        @(negedge clk);
        #2 nReset = 1'b1;
        for (int a = 0; a < 4; a++) fetch_chk("midrst_fetch", 5'(a), 14'h3000);

        // Randomized loads with gaps, stray controls and random fetch addresses.
        rnd_addr = 1'b1;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 4)) begin
                ld_valid = 1'($urandom_range(0, 1)); ld_data = 14'($urandom);
                tick();
            end
            ld_valid = 1'b0;
            start();
            len = $urandom_range(1, 40);
            x = '0;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    ld_start = 1'($urandom_range(0, 1)); ld_last = 1'($urandom_range(0, 1));
                    tick();
                end
                ld_start = 1'b0; ld_last = 1'b0;
                w = 14'($urandom);
`ifdef PROG_CHECKSUM_EN
                if (k == len - 1 && $urandom_range(0, 1) == 1) w = x;
`endif
                if (k < DEPTH) x ^= w;
                send(w, k == len - 1);
            end
            repeat ($urandom_range(2, 12)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
